// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: record types, event bundle layout and mask bit
// positions shared by the commit trace unit and its FIFO.
package commit_trace_pkg;

  typedef enum logic [1:0] {
    REG   = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    HALT  = 2'd3
  } rec_type_e;

  localparam int unsigned M_REG   = 0;
  localparam int unsigned M_LOAD  = 1;
  localparam int unsigned M_STORE = 2;
  localparam int unsigned M_HALT  = 3;

  typedef struct packed {
    logic [3:0]  mask;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
  } trace_bundle_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of event bundles; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  trace_bundle_t data_i,
  input  logic          pop_i,
  output trace_bundle_t head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_ok_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  trace_bundle_t mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign push_ok_o = do_push;
  assign head_o    = mem_q[rd_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: captures commit events, serializes trace records.
// Cache counters built only with COMMIT_TRACE_CACHE_STATS_EN defined.
module commit_trace_unit
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [2:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_type,
  output logic [15:0]      rec_a,
  output logic [15:0]      rec_b,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] icache_req_cnt,
  output logic [CNT_W-1:0] icache_hit_cnt,
  output logic [CNT_W-1:0] dcache_req_cnt,
  output logic [CNT_W-1:0] dcache_hit_cnt,
  output logic             halted,
  output logic             overflow
);

  logic             halted_q;
  logic             overflow_q;
  logic [CNT_W-1:0] inst_q;
  logic [CNT_W-1:0] cyc_q;
  logic [3:0]       done_q;
  trace_bundle_t    bun;
  trace_bundle_t    head;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             cap;
  logic             push;
  logic             hs;
  logic             last;
  logic             pop;
  logic [3:0]       rem;
  logic [3:0]       cur;
  rec_type_e        typ;
  logic [15:0]      ra;
  logic [15:0]      rb;

  assign cap  = ~halted_q;
  assign bun  = '{
    mask:  {halt, mem_write, mem_read, reg_write},
    rd:    write_reg,
    wdata: write_data,
    addr:  mem_addr,
    din:   mem_data_in,
    dout:  mem_data_out
  };
  assign push = cap & (|bun.mask);

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .data_i   (bun),
    .pop_i    (pop),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .push_ok_o(push_ok)
  );

  // Unconsumed bits of the head entry; lowest one is the live record.
  assign rem  = empty ? 4'd0 : (head.mask & ~done_q);
  assign cur  = rem & (~rem + 4'd1);
  assign last = ((rem & ~cur) == 4'd0);
  assign hs   = rec_valid & rec_ready;
  assign pop  = hs & last;

  assign rec_valid = ~empty;

  // Record fields from the registered head; counters are frozen by the
  // time a HALT record reaches the head, so they give the halt values.
  always_comb begin
    typ = REG;
    ra  = '0;
    rb  = '0;
    unique case (1'b1)
      cur[M_REG]: begin
        typ = REG;
        ra  = {13'b0, head.rd};
        rb  = head.wdata;
      end
      cur[M_LOAD]: begin
        typ = LOAD;
        ra  = head.addr;
        rb  = head.dout;
      end
      cur[M_STORE]: begin
        typ = STORE;
        ra  = head.addr;
        rb  = head.din;
      end
      cur[M_HALT]: begin
        typ = HALT;
        ra  = inst_q[15:0];
        rb  = cyc_q[15:0];
      end
      default: ;
    endcase
  end

  assign rec_type = typ;
  assign rec_a    = ra;
  assign rec_b    = rb;

  // Serializer progress, architectural counters, halt and overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      inst_q     <= '0;
      cyc_q      <= '0;
    end else begin
      if (hs) done_q <= last ? 4'd0 : (done_q | cur);
      if (cap) begin
        cyc_q <= cyc_q + CNT_W'(1);
        if (halt | reg_write | mem_write) inst_q <= inst_q + CNT_W'(1);
        if (halt) halted_q <= 1'b1;
        if (push & ~push_ok) overflow_q <= 1'b1;
      end
    end
  end

  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
  assign halted      = halted_q;
  assign overflow    = overflow_q;

`ifdef COMMIT_TRACE_CACHE_STATS_EN
  logic [CNT_W-1:0] ireq_q;
  logic [CNT_W-1:0] ihit_q;
  logic [CNT_W-1:0] dreq_q;
  logic [CNT_W-1:0] dhit_q;

  // Cache strobe counters, frozen with the rest after halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ireq_q <= '0;
      ihit_q <= '0;
      dreq_q <= '0;
      dhit_q <= '0;
    end else if (cap) begin
      ireq_q <= ireq_q + CNT_W'(icache_req);
      ihit_q <= ihit_q + CNT_W'(icache_hit);
      dreq_q <= dreq_q + CNT_W'(dcache_req);
      dhit_q <= dhit_q + CNT_W'(dcache_hit);
    end
  end

  assign icache_req_cnt = ireq_q;
  assign icache_hit_cnt = ihit_q;
  assign dcache_req_cnt = dreq_q;
  assign dcache_hit_cnt = dhit_q;
`else
  logic unused_cache;
  assign unused_cache = ^{icache_req, icache_hit, dcache_req, dcache_hit};

  assign icache_req_cnt = '0;
  assign icache_hit_cnt = '0;
  assign dcache_req_cnt = '0;
  assign dcache_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: directed plus random events against a
// queue-based record model of the commit trace unit.
module tb_commit_trace_unit;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg;
  logic [15:0] write_data, mem_addr, mem_data_in, mem_data_out;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic        rec_valid, rec_ready;
  logic [1:0]  rec_type;
  logic [15:0] rec_a, rec_b;
  logic [CNT_W-1:0] inst_count, cycle_count;
  logic [CNT_W-1:0] icache_req_cnt, icache_hit_cnt;
  logic [CNT_W-1:0] dcache_req_cnt, dcache_hit_cnt;
  logic        halted, overflow;

  commit_trace_unit #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .halt          (halt),
    .icache_req    (icache_req),
    .icache_hit    (icache_hit),
    .dcache_req    (dcache_req),
    .dcache_hit    (dcache_hit),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_type      (rec_type),
    .rec_a         (rec_a),
    .rec_b         (rec_b),
    .inst_count    (inst_count),
    .cycle_count   (cycle_count),
    .icache_req_cnt(icache_req_cnt),
    .icache_hit_cnt(icache_hit_cnt),
    .dcache_req_cnt(dcache_req_cnt),
    .dcache_hit_cnt(dcache_hit_cnt),
    .halted        (halted),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        mr;
    logic        mw;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        hlt;
    logic        ir;
    logic        ih;
    logic        dr;
    logic        dh;
  } ev_t;

  typedef struct {
    int               n;
    logic [3:0][1:0]  t;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
  } bund_t;

  bund_t       mq[$];
  int          hidx;
  logic [31:0] m_inst, m_cyc, m_ir, m_ih, m_dr, m_dh;
  bit          m_halt, m_ovf;
  int          vectors = 0;
  int          miscompares = 0;
  ev_t         e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hidx   = 0;
    m_inst = 0;
    m_cyc  = 0;
    m_ir   = 0;
    m_ih   = 0;
    m_dr   = 0;
    m_dh   = 0;
    m_halt = 0;
    m_ovf  = 0;
  endtask

  task automatic check_all();
    bit v;
    v = (mq.size() != 0);
    chk("rec_valid", rec_valid, v);
    if (v) begin
      chk("rec_type", rec_type, mq[0].t[hidx]);
      chk("rec_a", rec_a, mq[0].a[hidx]);
      chk("rec_b", rec_b, mq[0].b[hidx]);
    end
    chk("inst_count", inst_count, m_inst);
    chk("cycle_count", cycle_count, m_cyc);
    chk("halted", halted, m_halt);
    chk("overflow", overflow, m_ovf);
`ifdef COMMIT_TRACE_CACHE_STATS_EN
    chk("icache_req_cnt", icache_req_cnt, m_ir);
    chk("icache_hit_cnt", icache_hit_cnt, m_ih);
    chk("dcache_req_cnt", dcache_req_cnt, m_dr);
    chk("dcache_hit_cnt", dcache_hit_cnt, m_dh);
`else
    chk("icache_req_cnt", icache_req_cnt, 0);
    chk("icache_hit_cnt", icache_hit_cnt, 0);
    chk("dcache_req_cnt", dcache_req_cnt, 0);
    chk("dcache_hit_cnt", dcache_hit_cnt, 0);
`endif
  endtask

  task automatic model_edge(input ev_t ev, input logic rdy);
    bund_t nb;
    if (mq.size() != 0 && rdy) begin
      hidx++;
      if (hidx == mq[0].n) begin
        void'(mq.pop_front());
        hidx = 0;
      end
    end
    if (!m_halt) begin
      m_cyc++;
      if (ev.hlt || ev.rw || ev.mw) m_inst++;
      m_ir += 32'(ev.ir);
      m_ih += 32'(ev.ih);
      m_dr += 32'(ev.dr);
      m_dh += 32'(ev.dh);
      if (ev.hlt) m_halt = 1;
      nb.n = 0;
      nb.t = '0;
      nb.a = '0;
      nb.b = '0;
      if (ev.rw) begin
        nb.t[nb.n] = 2'd0; nb.a[nb.n] = {13'b0, ev.wr};
        nb.b[nb.n] = ev.wd; nb.n++;
      end
      if (ev.mr) begin
        nb.t[nb.n] = 2'd1; nb.a[nb.n] = ev.addr;
        nb.b[nb.n] = ev.dout; nb.n++;
      end
      if (ev.mw) begin
        nb.t[nb.n] = 2'd2; nb.a[nb.n] = ev.addr;
        nb.b[nb.n] = ev.din; nb.n++;
      end
      if (ev.hlt) begin
        nb.t[nb.n] = 2'd3; nb.a[nb.n] = m_inst[15:0];
        nb.b[nb.n] = m_cyc[15:0]; nb.n++;
      end
      if (nb.n != 0) begin
        if (mq.size() < DEPTH) mq.push_back(nb);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic cyc(input ev_t ev, input logic rdy);
    reg_write    = ev.rw;
    write_reg    = ev.wr;
    write_data   = ev.wd;
    mem_read     = ev.mr;
    mem_write    = ev.mw;
    mem_addr     = ev.addr;
    mem_data_in  = ev.din;
    mem_data_out = ev.dout;
    halt         = ev.hlt;
    icache_req   = ev.ir;
    icache_hit   = ev.ih;
    dcache_req   = ev.dr;
    dcache_hit   = ev.dh;
    rec_ready    = rdy;
    check_all();
    model_edge(ev, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset raised between edges; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic ev_t rnd_ev(input int hp);
    ev_t r;
    r.rw   = 1'($urandom_range(0, 1));
    r.wr   = 3'($urandom);
    r.wd   = 16'($urandom);
    r.mr   = 1'($urandom_range(0, 1));
    r.mw   = 1'($urandom_range(0, 1));
    r.addr = 16'($urandom);
    r.din  = 16'($urandom);
    r.dout = 16'($urandom);
    r.hlt  = ($urandom_range(0, hp - 1) == 0);
    r.ir   = 1'($urandom_range(0, 1));
    r.ih   = 1'($urandom_range(0, 1));
    r.dr   = 1'($urandom_range(0, 1));
    r.dh   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    e = '0;
    reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0;
    mem_data_in = 0; mem_data_out = 0; halt = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    rec_ready = 0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // single REG event, one-cycle latency
    e = '0; e.rw = 1; e.wr = 3'd3; e.wd = 16'hBEEF;
    cyc(e, 1'b1);
    chk("single_valid", rec_valid, 1);
    chk("single_a", rec_a, 16'h0003);
    chk("single_b", rec_b, 16'hBEEF);
    cyc('0, 1'b1);
    chk("single_inst", inst_count, 1);
    cyc('0, 1'b1);

    // full bundle with halt, from reset
    do_reset();
    e = '0; e.rw = 1; e.wr = 3'd1; e.wd = 16'h1111;
    e.mr = 1; e.mw = 1; e.addr = 16'h0040;
    e.dout = 16'h2222; e.din = 16'h3333; e.hlt = 1;
    cyc(e, 1'b1);
    repeat (3) cyc('0, 1'b1);
    chk("halt_type", rec_type, 2'd3);
    chk("halt_a", rec_a, 16'h0001);
    cyc('0, 1'b1);
    chk("halted", halted, 1);

    // post-halt freeze
    repeat (5) cyc(rnd_ev(2), 1'b1);
    chk("freeze_inst", inst_count, 1);
    chk("freeze_cycle", cycle_count, 1);

    // backpressure and overflow
    do_reset();
    repeat (9) begin
      e = '0; e.rw = 1; e.wr = 3'($urandom); e.wd = 16'($urandom);
      cyc(e, 1'b0);
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_inst", inst_count, 9);
    repeat (10) cyc('0, 1'b1);
    chk("ovf_drained", rec_valid, 0);

    // async reset with three records pending
    do_reset();
    repeat (3) begin
      e = '0; e.rw = 1; e.wr = 3'($urandom); e.wd = 16'($urandom);
      cyc(e, 1'b0);
    end
    do_reset();

    // cache strobes
    for (int i = 0; i < 3; i++) begin
      e = '0; e.ir = 1; e.ih = (i < 2);
      cyc(e, 1'b1);
    end
    cyc('0, 1'b1);
`ifdef COMMIT_TRACE_CACHE_STATS_EN
    chk("icache_req3", icache_req_cnt, 3);
    chk("icache_hit2", icache_hit_cnt, 2);
`else
    chk("icache_req0", icache_req_cnt, 0);
    chk("icache_hit0", icache_hit_cnt, 0);
`endif

    // random traffic with occasional halts and resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 7) == 0) do_reset();
      cyc(rnd_ev(40), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_unit.md
# commit_trace_unit

Synthesizable commit-trace producer inside the processor top (`p0`). Each clock it samples the core's commit-point event signals: register write, memory read, memory write, halt, and cache request/hit strobes. It buffers them in a FIFO and serializes them as typed trace records on a valid/ready stream, in the same per-cycle order the simulation trace uses (REG, LOAD, STORE, HALT). It also keeps the architectural instruction, cycle and cache counters, so a host, debug port or checker can consume the trace off-chip.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CNT_W`, 32, width of all counters
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `reg_write` in 1: register file written this cycle
- `write_reg` in 3: destination register
- `write_data` in 16: register write data
- `mem_read` in 1: data memory read
- `mem_write` in 1: data memory write
- `mem_addr` in 16: memory address
- `mem_data_in` in 16: store data
- `mem_data_out` in 16: load data
- `halt` in 1: halt reached commit
- `icache_req`, `icache_hit`, `dcache_req`, `dcache_hit` in 1 each: cache strobes
- `rec_valid` out 1: record available
- `rec_ready` in 1: consumer accepts
- `rec_type` out 2: 0 REG, 1 LOAD, 2 STORE, 3 HALT
- `rec_a` out 16: REG {13'b0,reg}; LOAD/STORE addr; HALT inst_count[15:0]
- `rec_b` out 16: REG data; LOAD mem_data_out; STORE mem_data_in; HALT cycle_count[15:0]
- `inst_count`, `cycle_count` out CNT_W: architectural counters
- `icache_req_cnt`, `icache_hit_cnt`, `dcache_req_cnt`, `dcache_hit_cnt` out CNT_W: cache counters
- `halted` out 1: halt captured
- `overflow` out 1: sticky, an event bundle was dropped

## Operation
- Reset values: all outputs are 0. The FIFO is empty. No clock edge is needed for reset to take effect.
- Capture runs on every rising edge while `halted`=0:
  - Build a bundle: mask {halt, mem_write, mem_read, reg_write} plus all data fields.
  - If the mask is non-zero, push the bundle.
  - A zero mask pushes nothing.
- Counters update on the capture edge, while `halted`=0 only:
  - `cycle_count` +1 every edge.
  - `inst_count` +1 when halt|reg_write|mem_write.
  - Cache counters +1 per asserted strobe.
  - All counters wrap modulo 2^CNT_W.
- On a halt capture, `halted`←1. All later events and counter updates are ignored until reset.
- HALT record contents:
  - `rec_a`: `inst_count` value after that edge's update, so it includes the halt.
  - `rec_b`: `cycle_count` after that edge's update. The first edge after reset counts as 1.
- Serializer:
  - `rec_valid` = FIFO non-empty.
  - The current record is the lowest set bit of the head entry's remaining mask, in order REG, LOAD, STORE, HALT.
  - On `rec_valid & rec_ready`: clear that bit. If it was the last bit, pop the entry.
  - `rec_type`/`rec_a`/`rec_b` must stay stable while `rec_valid` is high and `rec_ready` is low.
- Full FIFO:
  - If a pop happens on the same edge, the push is accepted.
  - Otherwise the bundle is dropped and `overflow`←1 (sticky).
  - Counters still update when a bundle is dropped.

## Timing
- Capture-to-`rec_valid` latency is 1 cycle: the event is sampled at edge N and `rec_valid` is high after edge N.
- Records are driven combinationally from the registered head entry. There is no combinational path from event inputs to `rec_*`.
- Throughput: 1 record per cycle with `rec_ready` held high. A 4-event bundle drains in 4 cycles.
- Asserting `rst` mid-drain clears `rec_valid` asynchronously. The partially drained entry is discarded.

## Configuration
- `COMMIT_TRACE_CACHE_STATS_EN` defined: the four cache counters are implemented as described.
- `COMMIT_TRACE_CACHE_STATS_EN` undefined: no cache counter flops are built. The four cache counter outputs are tied to 0 and the cache strobes are unused.
- The port list is identical either way.

## Structure
- `commit_trace_pkg` contains:
  - `rec_type_e` enum (REG=0, LOAD=1, STORE=2, HALT=3)
  - `trace_bundle_t` struct (4-bit mask, reg 3, wdata 16, addr 16, din 16, dout 16)
  - mask bit index constants
- One sub-module, `trace_fifo`: a synchronous FIFO of `trace_bundle_t` with push, pop, full, empty and the simultaneous push/pop-when-full rule.
- Serializer, counters and halt logic live in `commit_trace_unit`.

## Test plan
- Single-event latency: reg_write r3=0xBEEF, rec_ready=1 → one REG record, rec_a=0x0003, rec_b=0xBEEF, rec_valid one cycle after capture; inst_count=1.
- Full bundle ordering: one cycle with reg_write(r1=0x1111), mem_read(addr 0x0040, dout 0x2222), mem_write(din 0x3333), halt → records REG, LOAD(0x0040,0x2222), STORE(0x0040,0x3333), HALT(rec_a=1) on 4 consecutive cycles; halted=1.
- Backpressure and overflow: rec_ready=0, DEPTH=8, 9 consecutive reg_writes → overflow=1 and inst_count=9. Releasing rec_ready yields exactly the first 8 REG records.
- Post-halt freeze: events for 5 cycles after halt → no new records; cycle_count and inst_count unchanged.
- Asynchronous reset: assert rst between edges with 3 records pending → rec_valid=0 and all counters 0 before the next edge.
- Cache macro: icache_req for 3 cycles, icache_hit for 2 cycles → with `COMMIT_TRACE_CACHE_STATS_EN` defined, counts 3/2; without it, both 0.
